// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, the NOP
// encoding presented to decode when IF/ID is empty, and the IF/ID entry.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched instruction while decode stalls.
// Clear wins over write, write wins over read.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   wr,
    input  logic   rd,
    input  if_id_t din,
    output if_id_t dout,
    output logic   full
);

    if_id_t entry;

    // Capture one entry on wr, release it on rd, drop it on clr or reset.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            full  <= 1'b0;
            entry <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};
        end else if (wr) begin
            full  <= 1'b1;
            entry <= din;
        end else if (rd) begin
            full  <= 1'b0;
        end
    end

    assign dout = entry;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding word fetch at
// a time and hands {instr, pc, pc+4} to decode through a valid/ready IF/ID
// register. Redirects flush IF/ID and the skid buffer and discard the stale
// response. Optional performance counters are enabled by FETCH_PERF_CNT_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              DATA_WIDTH = 32,
    parameter int              ADDR_WIDTH = 32,
    parameter logic [31:0]     RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  id_valid,
    output logic [DATA_WIDTH-1:0] id_instr,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic [ADDR_WIDTH-1:0] id_pc_plus4,
    input  logic                  id_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_flushed
`endif
);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic                  req_q;
    logic                  skid_wr;
    logic                  skid_rd;
    logic                  skid_full;
    if_id_t                skid_in;
    if_id_t                skid_out;

    assign pc_plus4  = pc + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};
    assign imem_addr = pc;
    assign imem_req  = req_q && !skid_full;

    // Skid is written when a response arrives but IF/ID cannot take it,
    // and drained into IF/ID once decode becomes ready again.
    always_comb begin
        skid_in.instr    = imem_rdata;
        skid_in.pc       = pc;
        skid_in.pc_plus4 = pc_plus4;
        skid_wr = !redirect && (state == WAIT) && imem_rvalid && id_valid && !id_ready;
        skid_rd = !redirect && (state == HOLD) && id_ready;
    end

    fetch_skid_buf u_skid (
        .clk  (clk),
        .rst  (rst),
        .clr  (redirect),
        .wr   (skid_wr),
        .rd   (skid_rd),
        .din  (skid_in),
        .dout (skid_out),
        .full (skid_full)
    );

    // Fetch FSM with PC, request flag and IF/ID register; redirect overrides all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            req_q       <= 1'b0;
            id_valid    <= 1'b0;
            id_instr    <= NOP_INSTR;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
        end else begin
            if (id_valid && id_ready) begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end
            if (redirect) begin
                pc       <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
                case (state)
                    FETCH: begin
                        if (imem_req && imem_gnt) begin
                            state <= DRAIN;
                            req_q <= 1'b0;
                        end else begin
                            state <= FETCH;
                            req_q <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (imem_rvalid) begin
                            state <= FETCH;
                            req_q <= 1'b1;
                        end else begin
                            state <= DRAIN;
                            req_q <= 1'b0;
                        end
                    end
                    HOLD: begin
                        state <= FETCH;
                        req_q <= 1'b1;
                    end
                    default: begin
                        state <= DRAIN;
                        req_q <= 1'b0;
                    end
                endcase
            end else begin
                case (state)
                    FETCH: begin
                        if (imem_req && imem_gnt) begin
                            state <= WAIT;
                            req_q <= 1'b0;
                        end else begin
                            req_q <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (imem_rvalid) begin
                            pc <= pc_plus4;
                            if (!id_valid || id_ready) begin
                                id_valid    <= 1'b1;
                                id_instr    <= imem_rdata;
                                id_pc       <= pc;
                                id_pc_plus4 <= pc_plus4;
                                state       <= FETCH;
                                req_q       <= 1'b1;
                            end else begin
                                state <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (id_ready) begin
                            id_valid    <= 1'b1;
                            id_instr    <= skid_out.instr;
                            id_pc       <= skid_out.pc;
                            id_pc_plus4 <= skid_out.pc_plus4;
                            state       <= FETCH;
                            req_q       <= 1'b1;
                        end
                    end
                    default: begin
                        if (imem_rvalid) begin
                            state <= FETCH;
                            req_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic if_id_load;

    assign if_id_load = !redirect &&
                        (((state == WAIT) && imem_rvalid && (!id_valid || id_ready)) ||
                         ((state == HOLD) && id_ready));

    // Count IF/ID loads and redirect cycles; both wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (if_id_load) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (redirect) begin
                perf_flushed <= perf_flushed + 32'd1;
            end
        end
    end
`else
    // Performance counters compiled out.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a small instruction-memory model
// that grants whenever enabled and answers after a programmable latency.
// Instruction words are {16'hC0DE, addr[15:0]}.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_ready;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    logic        gnt_en;
    int          mem_lat;
    int          mem_cnt;
    logic [31:0] mem_addr_q;

    int total;
    int bad;

    fetch_stage #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_ready    (id_ready)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: accept on req when enabled, respond mem_lat cycles later.
    assign imem_gnt    = imem_req && gnt_en;
    assign imem_rvalid = (mem_cnt == 1);
    assign imem_rdata  = imem_rvalid ? {16'hC0DE, mem_addr_q[15:0]} : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (rst) begin
            mem_cnt    <= 0;
            mem_addr_q <= '0;
        end else if (imem_req && imem_gnt) begin
            mem_cnt    <= mem_lat;
            mem_addr_q <= imem_addr;
        end else if (mem_cnt > 0) begin
            mem_cnt <= mem_cnt - 1;
        end
    end

    // Safety net in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic rd, input logic [31:0] rpc,
                                 input logic rdy);
        rst         = r;
        redirect    = rd;
        redirect_pc = rpc;
        id_ready    = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        gnt_en  = 1'b1;
        mem_lat = 1;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

        // Reset state
        tick();
        tick();
        checkOutput("rst_req",      {31'b0, imem_req}, 32'd0);
        checkOutput("rst_addr",     imem_addr,         32'h0);
        checkOutput("rst_valid",    {31'b0, id_valid}, 32'd0);
        checkOutput("rst_instr",    id_instr,          NOP);
        checkOutput("rst_pc",       id_pc,             32'h0);
        checkOutput("rst_pc4",      id_pc_plus4,       32'h0);

        // Streaming fetch at one instruction per two cycles
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("s_req0",   {31'b0, imem_req}, 32'd1);
        checkOutput("s_addr0",  imem_addr,         32'h0);
        tick();
        checkOutput("s_wait",   {31'b0, imem_req}, 32'd0);
        checkOutput("s_nv0",    {31'b0, id_valid}, 32'd0);
        tick();
        checkOutput("s_v0",     {31'b0, id_valid}, 32'd1);
        checkOutput("s_instr0", id_instr,          32'hC0DE_0000);
        checkOutput("s_pc0",    id_pc,             32'h0);
        checkOutput("s_pc4_0",  id_pc_plus4,       32'h4);
        checkOutput("s_addr4",  imem_addr,         32'h4);
        tick();
        checkOutput("s_drop",   {31'b0, id_valid}, 32'd0);
        tick();
        checkOutput("s_instr4", id_instr,          32'hC0DE_0004);
        checkOutput("s_pc4",    id_pc,             32'h4);
        checkOutput("s_pc4_4",  id_pc_plus4,       32'h8);
        checkOutput("s_addr8",  imem_addr,         32'h8);
        tick();
        tick();
        checkOutput("s_pc8",    id_pc,             32'h8);
        checkOutput("s_pc4_8",  id_pc_plus4,       32'hC);

        // Decode stall: second response goes to skid, no request while holding
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("k_pc0",    id_pc,             32'h0);
        tick();
        tick();
        checkOutput("k_hold1",  {31'b0, imem_req}, 32'd0);
        tick();
        checkOutput("k_hold2",  {31'b0, imem_req}, 32'd0);
        checkOutput("k_stable", id_instr,          32'hC0DE_0000);
        tick();
        checkOutput("k_hold3",  {31'b0, imem_req}, 32'd0);
        checkOutput("k_pcst",   id_pc,             32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("k_v4",     {31'b0, id_valid}, 32'd1);
        checkOutput("k_instr4", id_instr,          32'hC0DE_0004);
        checkOutput("k_pc4",    id_pc,             32'h4);
        checkOutput("k_pc4_4",  id_pc_plus4,       32'h8);
        checkOutput("k_req",    {31'b0, imem_req}, 32'd1);
        checkOutput("k_addr8",  imem_addr,         32'h8);
        tick();
        checkOutput("k_nv",     {31'b0, id_valid}, 32'd0);
        tick();
        checkOutput("k_pc8",    id_pc,             32'h8);

        // Redirect in WAIT without a response: drain the stale one
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        mem_lat = 3;
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        tick();
        checkOutput("r1_nv",    {31'b0, id_valid}, 32'd0);
        checkOutput("r1_nop",   id_instr,          NOP);
        checkOutput("r1_req",   {31'b0, imem_req}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("r1_drain", {31'b0, imem_req}, 32'd0);
        tick();
        checkOutput("r1_req2",  {31'b0, imem_req}, 32'd1);
        checkOutput("r1_addr",  imem_addr,         32'h0000_0100);
        checkOutput("r1_nv2",   {31'b0, id_valid}, 32'd0);
        mem_lat = 1;
        tick();
        tick();
        checkOutput("r1_pc",    id_pc,             32'h0000_0100);
        checkOutput("r1_instr", id_instr,          32'hC0DE_0100);

        // Redirect coincident with rvalid: response dropped, low bits masked
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_0203, 1'b1);
        tick();
        checkOutput("r2_addr",  imem_addr,         32'h0000_0200);
        checkOutput("r2_req",   {31'b0, imem_req}, 32'd1);
        checkOutput("r2_nv",    {31'b0, id_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        tick();
        checkOutput("r2_pc",    id_pc,             32'h0000_0200);
        checkOutput("r2_pc4",   id_pc_plus4,       32'h0000_0204);
        checkOutput("r2_instr", id_instr,          32'hC0DE_0200);

        // PC wrap at the top of the address space
        gnt_en = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        tick();
        checkOutput("w_addr",   imem_addr,         32'hFFFF_FFFC);
        checkOutput("w_req",    {31'b0, imem_req}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        gnt_en = 1'b1;
        tick();
        tick();
        checkOutput("w_pc",     id_pc,             32'hFFFF_FFFC);
        checkOutput("w_pc4",    id_pc_plus4,       32'h0);
        checkOutput("w_instr",  id_instr,          32'hC0DE_FFFC);
        checkOutput("w_next",   imem_addr,         32'h0);

        // Redirect in FETCH with grant: the granted response is drained
        applyStimulus(1'b0, 1'b1, 32'h0000_0040, 1'b1);
        tick();
        checkOutput("f_drain",  {31'b0, imem_req}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("f_req",    {31'b0, imem_req}, 32'd1);
        checkOutput("f_addr",   imem_addr,         32'h0000_0040);
        checkOutput("f_nv",     {31'b0, id_valid}, 32'd0);

        // Reset in the middle of a transaction
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("m_req",    {31'b0, imem_req}, 32'd0);
        checkOutput("m_addr",   imem_addr,         32'h0);
        checkOutput("m_nv",     {31'b0, id_valid}, 32'd0);
        checkOutput("m_nop",    id_instr,          NOP);

        // Ten fetches followed by two redirect cycles
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            tick();
        end
        checkOutput("p_pc",     id_pc,             32'h0000_0024);
        checkOutput("p_valid",  {31'b0, id_valid}, 32'd1);
        gnt_en = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h0000_0080, 1'b1);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("p_addr",   imem_addr,         32'h0000_0080);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("p_fetched", perf_fetched,     32'd10);
        checkOutput("p_flushed", perf_flushed,     32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the control unit: owns the PC, issues word fetches to instruction memory, and presents {instr, pc, pc+4} to decode via a valid/ready IF/ID register.
- Redirects from branch/jump/jalr resolution flush in-flight work.
- Holds one response in a skid buffer so a decode stall never loses an instruction.

Parameters:
- DATA_WIDTH, 32, instruction/data word width
- ADDR_WIDTH, 32, PC width
- RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_WIDTH  fetch word address (= pc)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid
- imem_rdata  in  DATA_WIDTH  fetched instruction
- redirect  in  1  taken branch/jump/jalr, flush
- redirect_pc  in  ADDR_WIDTH  new PC
- id_valid  out  1  IF/ID register holds valid instruction
- id_instr  out  DATA_WIDTH  instruction to control unit
- id_pc  out  ADDR_WIDTH  PC of id_instr
- id_pc_plus4  out  ADDR_WIDTH  id_pc + 4
- id_ready  in  1  decode accepts IF/ID this cycle

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst; clock port is clk.
- Reset values:
  - pc = RESET_PC, state = FETCH.
  - imem_req = 0 during the reset cycle, then asserted from the first cycle after rst deasserts.
  - id_valid = 0, id_instr = NOP (32'h0000_0013), id_pc = 0, id_pc_plus4 = 0, skid buffer empty.
- States: FETCH, WAIT, HOLD, DRAIN.
  - FETCH: imem_req = 1, imem_addr = pc. On gnt: go to WAIT. Stay in FETCH while gnt = 0. Requests are issued only when skid is empty.
  - WAIT: imem_req = 0. On rvalid:
    - if IF/ID is empty or drained this cycle (id_ready & id_valid): load IF/ID with {rdata, pc, pc+4}, pc += 4, go to FETCH;
    - otherwise: write skid buffer with {rdata, pc}, pc += 4, go to HOLD.
  - HOLD: imem_req = 0. When id_ready: move skid into IF/ID the same edge, go to FETCH.
  - DRAIN: imem_req = 0. Discard the next rvalid, then go to FETCH with the redirected pc.
- Latency: earliest gnt-to-id_valid is 2 cycles (gnt in FETCH, rvalid in the following WAIT cycle, IF/ID loaded on that edge). Throughput is at most one instruction per 2 cycles (single outstanding request by design).
- IF/ID handshake:
  - id_valid & id_ready transfers the entry; if nothing reloads, id_valid drops next cycle.
  - With id_ready = 0, id_instr, id_pc and id_pc_plus4 are held stable.
  - When id_valid = 0, id_instr = NOP.
- Redirect has highest priority in every state:
  - pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}; id_valid <= 0; id_instr <= NOP; skid cleared.
  - Next state by case:
    - FETCH with gnt in the same cycle: DRAIN.
    - FETCH without gnt: FETCH.
    - WAIT with rvalid in the same cycle: response dropped, go to FETCH.
    - WAIT without rvalid: DRAIN.
    - HOLD: FETCH.
    - DRAIN: DRAIN. The one stale response is still owed; redirect only updates pc.
- Arithmetic: pc + 4 is modulo 2^ADDR_WIDTH; 32'hFFFF_FFFC wraps to 0 with no error.
- imem_rvalid outside WAIT/DRAIN is ignored.
- rst mid-transaction: returns to reset state next edge. Memory is reset by the same rst, so no drain is needed.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32-bit, +1 per IF/ID load) and perf_flushed (32-bit, +1 per redirect cycle). Both reset to 0 and wrap on overflow.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {FETCH, WAIT, HOLD, DRAIN}
  - localparam NOP_INSTR = 32'h0000_0013
  - if_id_t struct {instr, pc, pc_plus4}
- Sub-module fetch_skid_buf: one-entry if_id_t buffer with wr/rd/clr and full flag.

Test Plan:
- Reset with RESET_PC = 0; memory returns rvalid 1 cycle after gnt, id_ready = 1 → imem_addr sequence 0, 4, 8; id_pc 0, 4, 8 with id_pc_plus4 4, 8, 12; one instruction every 2 cycles.
- id_ready = 0 for 5 cycles after first instr → second response captured in skid, no request issued in HOLD. Raise id_ready → instrs at pc 0, 4 delivered in order, then fetch resumes at 8.
- Redirect to 32'h100 while in WAIT (no rvalid) → id_valid drops next cycle, next rvalid discarded, next imem_addr = 32'h100.
- Redirect to 32'h203 coincident with rvalid → response dropped, imem_addr = 32'h200 next cycle.
- pc = 32'hFFFF_FFFC fetched → id_pc_plus4 = 0, next imem_addr = 0.
- With FETCH_PERF_CNT_EN, 10 fetches and 2 redirects → perf_fetched = 10, perf_flushed = 2.
